// File: rtl/mc_transposed_fir.sv
// Multi-channel time-interleaved transposed-form FIR with double-buffered coefficients.
// Define FIR_ROUND_EN for round-half-up output conversion; default is truncation.
module mc_transposed_fir #(
    parameter int WIDTH    = 16,
    parameter int FRAC     = 15,
    parameter int TAPS     = 8,
    parameter int CHANNELS = 4,
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int AW = (TAPS > 1) ? $clog2(TAPS) : 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] din,
    input  logic             din_ovr,
    input  logic             din_valid,
    output logic             din_ready,
    output logic [WIDTH-1:0] dout,
    output logic [CW-1:0]    dout_ch,
    output logic             dout_ovr,
    output logic             dout_valid,
    input  logic             dout_ready,
    input  logic             coef_wr_en,
    input  logic [AW-1:0]    coef_wr_addr,
    input  logic [WIDTH-1:0] coef_wr_data,
    input  logic             coef_commit,
    output logic             coef_pending
);

    localparam int ACC = 2 * WIDTH + $clog2(TAPS);
    localparam logic signed [ACC:0] SMAX = (ACC+1)'((1 << (WIDTH - 1)) - 1);
    localparam logic signed [ACC:0] SMIN = ~SMAX;
`ifdef FIR_ROUND_EN
    localparam logic signed [ACC:0] RND = (ACC+1)'(1) << (FRAC - 1);
`else
    localparam logic signed [ACC:0] RND = '0;
`endif

    logic signed [WIDTH-1:0] act    [TAPS];
    logic signed [WIDTH-1:0] shadow [TAPS];
    logic signed [ACC-1:0]   ps     [CHANNELS][TAPS-1];
    logic signed [ACC-1:0]   p      [TAPS];

    logic [CW-1:0]         ch_cnt;
    logic                  rdy_q;
    logic                  swap;
    logic                  accept;
    logic signed [ACC-1:0] xe;
    logic signed [ACC-1:0] y;
    logic signed [ACC:0]   yr;
    logic signed [ACC:0]   ys;
    logic                  sat;
    logic [WIDTH-1:0]      dsat;

    // Swap only at a frame boundary so every channel of a frame shares one bank.
    assign swap      = coef_pending && (ch_cnt == '0);
    assign din_ready = rdy_q && (!dout_valid || dout_ready) && !swap;
    assign accept    = din_valid && din_ready;

    always_comb begin
        xe = ACC'($signed(din));
        for (int i = 0; i < TAPS; i++)
            p[i] = xe * ACC'(act[TAPS-1-i]);
        y    = p[TAPS-1] + ps[ch_cnt][TAPS-2];
        yr   = {y[ACC-1], y} + RND;
        ys   = yr >>> FRAC;
        sat  = 1'b0;
        dsat = ys[WIDTH-1:0];
        if (ys > SMAX) begin
            sat  = 1'b1;
            dsat = SMAX[WIDTH-1:0];
        end else if (ys < SMIN) begin
            sat  = 1'b1;
            dsat = SMIN[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rdy_q <= 1'b0;
        end else begin
            rdy_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ch_cnt <= '0;
        end else if (accept) begin
            if (ch_cnt == CW'(CHANNELS - 1))
                ch_cnt <= '0;
            else
                ch_cnt <= ch_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dout       <= '0;
            dout_ch    <= '0;
            dout_ovr   <= 1'b0;
            dout_valid <= 1'b0;
        end else if (accept) begin
            dout       <= dsat;
            dout_ch    <= ch_cnt;
            dout_ovr   <= din_ovr | sat;
            dout_valid <= 1'b1;
        end else if (dout_ready) begin
            dout_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int c = 0; c < CHANNELS; c++)
                for (int i = 0; i < TAPS - 1; i++)
                    ps[c][i] <= '0;
        end else if (accept) begin
            ps[ch_cnt][0] <= p[0];
            for (int i = 1; i < TAPS - 1; i++)
                ps[ch_cnt][i] <= p[i] + ps[ch_cnt][i-1];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            coef_pending <= 1'b0;
            for (int i = 0; i < TAPS; i++) begin
                act[i]    <= '0;
                shadow[i] <= '0;
            end
        end else begin
            if (coef_wr_en && !coef_pending && (int'(coef_wr_addr) < TAPS))
                shadow[coef_wr_addr] <= coef_wr_data;
            if (swap) begin
                act          <= shadow;
                coef_pending <= 1'b0;
            end else if (coef_commit) begin
                coef_pending <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mc_transposed_fir.sv
// Bench for mc_transposed_fir: direct-form reference model plus directed vectors.
module tb_mc_transposed_fir;

    localparam int WIDTH = 16;
    localparam int FRAC  = 15;
    localparam int TAPS  = 4;
    localparam int CH    = 2;

    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic [15:0] din = '0;
    logic        din_ovr = 1'b0;
    logic        din_valid = 1'b0;
    logic        din_ready;
    logic [15:0] dout;
    logic [0:0]  dout_ch;
    logic        dout_ovr;
    logic        dout_valid;
    logic        dout_ready = 1'b1;
    logic        coef_wr_en = 1'b0;
    logic [1:0]  coef_wr_addr = '0;
    logic [15:0] coef_wr_data = '0;
    logic        coef_commit = 1'b0;
    logic        coef_pending;

    mc_transposed_fir #(
        .WIDTH(WIDTH), .FRAC(FRAC), .TAPS(TAPS), .CHANNELS(CH)
    ) dut (
        .clk(clk), .rstn(rstn),
        .din(din), .din_ovr(din_ovr), .din_valid(din_valid),
        .din_ready(din_ready),
        .dout(dout), .dout_ch(dout_ch), .dout_ovr(dout_ovr),
        .dout_valid(dout_valid), .dout_ready(dout_ready),
        .coef_wr_en(coef_wr_en), .coef_wr_addr(coef_wr_addr),
        .coef_wr_data(coef_wr_data), .coef_commit(coef_commit),
        .coef_pending(coef_pending)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        int          ch;
        logic [15:0] d;
        bit          ovr;
    } obs_t;
    obs_t obs_q[$];

    // Reference: every sample keeps the bank that was live when it arrived.
    int          hx [CH][TAPS];
    int          hb [CH][TAPS][TAPS];
    int          act_m [TAPS];
    int          sh_m  [TAPS];
    bit          pend_m = 0;
    bit          rdy_m = 0;
    bit          vld_m = 0;
    int          ch_m = 0;
    logic [15:0] e_dout = '0;
    int          e_ch = 0;
    bit          e_ovr = 0;

    initial begin
        for (int c = 0; c < CH; c++)
            for (int a = 0; a < TAPS; a++) begin
                hx[c][a] = 0;
                for (int k = 0; k < TAPS; k++) hb[c][a][k] = 0;
            end
        for (int k = 0; k < TAPS; k++) begin
            act_m[k] = 0;
            sh_m[k]  = 0;
        end
    end

    always @(negedge clk) begin
        bit     swap_m, rdy_e, acc, so;
        longint yv, q;
        int     c;
        if (!rstn) begin
            for (int cc = 0; cc < CH; cc++)
                for (int a = 0; a < TAPS; a++) begin
                    hx[cc][a] = 0;
                    for (int k = 0; k < TAPS; k++) hb[cc][a][k] = 0;
                end
            for (int k = 0; k < TAPS; k++) begin
                act_m[k] = 0;
                sh_m[k]  = 0;
            end
            pend_m = 0; rdy_m = 0; vld_m = 0; ch_m = 0;
            e_dout = '0; e_ch = 0; e_ovr = 0;
            n_vec++;
            if (dout_valid !== 1'b0 || din_ready !== 1'b0 ||
                coef_pending !== 1'b0 || dout !== 16'h0 ||
                dout_ch !== 1'b0 || dout_ovr !== 1'b0) begin
                n_err++;
                $display("FAIL reset_state @%0t: vld %b rdy %b pend %b dout %h ch %0d ovr %b, required all 0",
                         $time, dout_valid, din_ready, coef_pending, dout, dout_ch, dout_ovr);
            end
        end else begin
            swap_m = pend_m && (ch_m == 0);
            rdy_e  = rdy_m && (!vld_m || dout_ready) && !swap_m;
            n_vec++;
            if (din_ready !== rdy_e || dout_valid !== vld_m ||
                coef_pending !== pend_m ||
                (vld_m && (dout !== e_dout || dout_ch !== e_ch[0] ||
                           dout_ovr !== e_ovr))) begin
                n_err++;
                $display("FAIL cycle @%0t: rdy %b/%b vld %b/%b pend %b/%b dout %h/%h ch %0d/%0d ovr %b/%b (actual/required)",
                         $time, din_ready, rdy_e, dout_valid, vld_m,
                         coef_pending, pend_m, dout, e_dout,
                         dout_ch, e_ch, dout_ovr, e_ovr);
            end
            if (dout_valid && dout_ready)
                obs_q.push_back('{int'(dout_ch), dout, dout_ovr});
            acc = din_valid && rdy_e;
            if (acc) begin
                c = ch_m;
                for (int a = TAPS - 1; a > 0; a--) begin
                    hx[c][a] = hx[c][a-1];
                    hb[c][a] = hb[c][a-1];
                end
                hx[c][0] = int'($signed(din));
                hb[c][0] = act_m;
                yv = 0;
                for (int a = 0; a < TAPS; a++)
                    yv += longint'(hx[c][a]) * longint'(hb[c][a][a]);
`ifdef FIR_ROUND_EN
                yv += longint'(1) << (FRAC - 1);
`endif
                q  = yv >>> FRAC;
                so = din_ovr;
                if (q > 32767) begin
                    q = 32767; so = 1;
                end else if (q < -32768) begin
                    q = -32768; so = 1;
                end
                e_dout = q[15:0];
                e_ch   = c;
                e_ovr  = so;
                vld_m  = 1;
                ch_m   = (ch_m + 1) % CH;
            end else if (dout_ready) begin
                vld_m = 0;
            end
            if (coef_wr_en && !pend_m)
                sh_m[coef_wr_addr] = int'($signed(coef_wr_data));
            if (swap_m) begin
                act_m  = sh_m;
                pend_m = 0;
            end else if (coef_commit) begin
                pend_m = 1;
            end
            rdy_m = 1;
        end
    end

    task automatic chk(input string name, input longint got, input longint exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h", name, got, exp);
        end
    endtask

    task automatic pop_chk(input string name, input int ch,
                           input logic [15:0] d, input bit ovr);
        obs_t o;
        n_vec++;
        if (obs_q.size() == 0) begin
            n_err++;
            $display("FAIL %s: no output, required ch %0d dout %h ovr %b",
                     name, ch, d, ovr);
        end else begin
            o = obs_q.pop_front();
            if (o.ch != ch || o.d !== d || o.ovr != ovr) begin
                n_err++;
                $display("FAIL %s: ch %0d dout %h ovr %b, required ch %0d dout %h ovr %b",
                         name, o.ch, o.d, o.ovr, ch, d, ovr);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] x, input bit ovr);
        int n;
        bit done;
        din       = x;
        din_ovr   = ovr;
        din_valid = 1'b1;
        n         = 0;
        done      = 0;
        while (!done) begin
            @(negedge clk);
            if (din_ready) begin
                done = 1;
            end else begin
                n++;
                if (n > 50) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL send_timeout: din_ready 0 for %0d cycles, required 1", n);
                    done = 1;
                end
            end
        end
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        din_ovr   = 1'b0;
    endtask

    task automatic wr(input int a, input logic [15:0] d);
        coef_wr_en   = 1'b1;
        coef_wr_addr = a[1:0];
        coef_wr_data = d;
        tick();
        coef_wr_en   = 1'b0;
    endtask

    task automatic commit();
        coef_commit = 1'b1;
        tick();
        coef_commit = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] imp [6];
        logic [15:0] stp [6];
        imp = '{16'h3FFF, 16'h1FFF, 16'h0FFF, 16'h07FF, 16'h0000, 16'h0000};
        stp = '{16'h2000, 16'h3000, 16'h3800, 16'h3C00, 16'h3C00, 16'h3C00};

        #1 rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_dout_valid", dout_valid, 0);
        chk("rst_din_ready", din_ready, 0);
        chk("rst_pending", coef_pending, 0);
        chk("rst_dout", dout, 0);
        rstn = 1'b1;
        chk("ready_low_at_release", din_ready, 0);
        tick();
        chk("ready_high_first_edge", din_ready, 1);

        wr(0, 16'h4000); wr(1, 16'h2000); wr(2, 16'h1000); wr(3, 16'h0800);
        commit();
        tick(); tick();
        chk("pending_cleared", coef_pending, 0);

        obs_q.delete();
        send(16'h7FFF, 0); send(16'h0000, 0);
        for (int k = 1; k < 6; k++) begin
            send(16'h0000, 0); send(16'h0000, 0);
        end
        send(16'h0000, 1); send(16'h0000, 0);
        tick(); tick();
        for (int k = 0; k < 6; k++) begin
            pop_chk("impulse_ch0", 0, imp[k], 0);
            pop_chk("impulse_ch1", 1, 16'h0000, 0);
        end
        pop_chk("ovr_passthrough", 0, 16'h0000, 1);
        pop_chk("ovr_other_ch", 1, 16'h0000, 0);

        obs_q.delete();
        for (int k = 0; k < 6; k++) begin
            send(16'h0000, 0); send(16'h4000, 0);
        end
        tick(); tick();
        for (int k = 0; k < 6; k++) begin
            pop_chk("indep_ch0", 0, 16'h0000, 0);
            pop_chk("step_ch1", 1, stp[k], 0);
        end

        wr(0, 16'h7FFF); wr(1, 16'h7FFF); wr(2, 16'h7FFF); wr(3, 16'h7FFF);
        commit();
        tick(); tick();
        obs_q.delete();
        for (int k = 0; k < 4; k++) begin
            send(16'h7FFF, 0); send(16'h7FFF, 0);
        end
        for (int k = 0; k < 4; k++) begin
            send(16'h8000, 0); send(16'h8000, 0);
        end
        tick(); tick();
        pop_chk("sat_first_ch0", 0, 16'h7FFE, 0);
        void'(obs_q.pop_front());
        for (int k = 1; k < 4; k++) begin
            pop_chk("sat_pos_ch0", 0, 16'h7FFF, 1);
            pop_chk("sat_pos_ch1", 1, 16'h7FFF, 1);
        end
        repeat (4) void'(obs_q.pop_front());
        for (int k = 2; k < 4; k++) begin
            pop_chk("sat_neg_ch0", 0, 16'h8000, 1);
            pop_chk("sat_neg_ch1", 1, 16'h8000, 1);
        end

        obs_q.delete();
        dout_ready = 1'b0;
        send(16'h1000, 0);
        din       = 16'h2000;
        din_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("bp_ready_low", din_ready, 0);
            chk("bp_dout_held", dout, 16'h8000);
            chk("bp_ch_held", dout_ch, 0);
        end
        @(posedge clk);
        #1;
        dout_ready = 1'b1;
        send(16'h2000, 0);
        send(16'h3000, 0);
        tick(); tick();
        chk("bp_count", obs_q.size(), 3);
        if (obs_q.size() == 3) begin
            chk("bp_order0", obs_q[0].ch, 0);
            chk("bp_order1", obs_q[1].ch, 1);
            chk("bp_order2", obs_q[2].ch, 0);
        end

        wr(0, 16'h2000); wr(1, 16'h0000); wr(2, 16'h0000); wr(3, 16'h0000);
        commit();
        @(negedge clk);
        chk("commit_pending", coef_pending, 1);
        chk("commit_ready_ch1", din_ready, 1);
        @(posedge clk);
        #1;
        wr(0, 16'h7FFF);
        send(16'h0100, 0);
        @(negedge clk);
        chk("swap_ready_low", din_ready, 0);
        chk("swap_pending_high", coef_pending, 1);
        @(negedge clk);
        chk("swap_ready_back", din_ready, 1);
        chk("swap_pending_low", coef_pending, 0);
        @(posedge clk);
        #1;
        for (int k = 0; k < 6; k++) send(16'h0000, 0);
        tick();
        obs_q.delete();
        send(16'h4000, 0);
        tick(); tick();
        pop_chk("new_bank_shadow_kept", 0, 16'h1000, 0);

        dout_ready = 1'b0;
        send(16'h4000, 0);
        tick();
        #3 rstn = 1'b0;
        #1;
        chk("arst_dout", dout, 0);
        chk("arst_valid", dout_valid, 0);
        chk("arst_ch", dout_ch, 0);
        chk("arst_ovr", dout_ovr, 0);
        chk("arst_pending", coef_pending, 0);
        chk("arst_ready", din_ready, 0);
        @(posedge clk);
        #1;
        dout_ready = 1'b1;
        rstn       = 1'b1;
        tick();
        obs_q.delete();
        send(16'h7FFF, 0);
        tick(); tick();
        pop_chk("post_reset_first", 0, 16'h0000, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mc_transposed_fir.md
# mc_transposed_fir

Multi-channel, time-interleaved, transposed-form FIR filter with a valid/ready streaming interface, runtime-reloadable double-buffered coefficients, and a saturating fixed-point output. It is the parametrised successor to the single-channel fixed-coefficient transposed FIR in the adaptive-filter datapath. It serves CHANNELS independent streams with one multiplier bank. The adaptive update engine writes the coefficients and swaps them atomically at frame boundaries.

## Interface
- WIDTH, 16: sample/coefficient width, signed two's complement
- FRAC, 15: fractional bits of samples, coefficients and output
- TAPS, 8: filter length, ≥2
- CHANNELS, 4: interleaved channels, ≥1
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- din  in  WIDTH  input sample
- din_ovr  in  1  upstream overflow flag, travels with the sample
- din_valid  in  1  sample present
- din_ready  out  1  sample accepted when valid&&ready
- dout  out  WIDTH  filtered sample
- dout_ch  out  max(1,clog2(CHANNELS))  channel of dout
- dout_ovr  out  1  din_ovr of the sample OR saturation occurred
- dout_valid  out  1  output present
- dout_ready  in  1  downstream accepts
- coef_wr_en  in  1  write the shadow coefficient bank
- coef_wr_addr  in  max(1,clog2(TAPS))  tap index k (h[k] multiplies x[n-k])
- coef_wr_data  in  WIDTH  coefficient
- coef_commit  in  1  request a shadow→active swap
- coef_pending  out  1  swap requested but not yet applied

## Operation
- Channel counter ch_cnt starts at 0. It increments on each accepted sample and wraps from CHANNELS-1 to 0. Input samples arrive in strict channel order.
- Partial-sum state ps[i][c] is kept for i=0..TAPS-2 and every channel c. The accumulator width is ACC=2·WIDTH+clog2(TAPS), with 2·FRAC fractional bits.
- On accepting sample x for channel c:
  - p[i]=x·h[TAPS-1-i], full precision, sign-extended to ACC.
  - y=p[TAPS-1]+ps[TAPS-2][c].
  - ps[i][c]←p[i]+ps[i-1][c] for i≥1.
  - ps[0][c]←p[0].
  - State of the other channels is untouched.
- Output conversion: y is shifted right by FRAC and saturated to the signed WIDTH range. Saturation sets dout_ovr. dout_ovr also ORs in din_ovr.
- Coefficients:
  - coef_wr_en writes shadow[coef_wr_addr]. Writes are ignored while coef_pending=1.
  - A coef_commit pulse sets coef_pending.
  - The swap (active←shadow) happens on the first edge where coef_pending=1 and ch_cnt=0. It then clears coef_pending.
  - din_ready is held low during that swap cycle, so no sample sees a half-swapped bank.
  - ps state is not cleared on a swap. The first TAPS-1 samples per channel after a swap mix old and new coefficients. This is intended.
- din_ready = (!dout_valid || dout_ready) && !(coef_pending && ch_cnt==0).
- Reset mid-stream discards all state. The next accepted sample is treated as channel 0.

## Timing
- Latency: a sample accepted at edge n appears on dout/dout_ch/dout_ovr with dout_valid=1 after edge n. That is one register stage.
- Output hold: dout, dout_ch, dout_ovr and dout_valid hold while dout_valid && !dout_ready.
- Throughput: with dout_ready held high, one sample per cycle.
- dout_valid clears on the edge where the output is taken and no new sample is accepted.
- Same-cycle events:
  - Commit and wr_en together: the write lands first, then pending is set.
  - Commit while pending: no effect.
- Reset values: dout=0, dout_ch=0, dout_ovr=0, dout_valid=0, coef_pending=0. Also ch_cnt=0, all ps=0, active and shadow banks=0.
- din_ready is low during reset and goes high on the first edge after rstn deasserts.

## Configuration
- FIR_ROUND_EN defined: round half-up before saturation. 2^(FRAC-1) is added to y before the shift. Saturation covers the rounding overflow.
- FIR_ROUND_EN undefined: truncation, an arithmetic shift toward −∞.

## Test plan
All cases use WIDTH=16, FRAC=15, TAPS=4, CHANNELS=2.
- Impulse per channel:
  - Load h={0x4000,0x2000,0x1000,0x0800} and commit.
  - Send ch0 impulse 0x7FFF, then zeros; ch1 stays zero throughout.
  - Required: ch0 outputs 0x3FFF,0x1FFF,0x0FFF,0x07FF, then 0. Truncation applies, so the values are one LSB below the rounded ones. ch1 outputs are all 0.
- Channel independence:
  - Use the same coefficients. Send ch1 step input 0x4000, ch0 zeros.
  - Required: ch1 settles to 0x3C00; ch0 stays 0.
- Saturation:
  - Set all h=0x7FFF and drive din=0x7FFF continuously.
  - Required: dout=0x7FFF with dout_ovr=1 from the 2nd sample per channel on.
  - With din=0x8000, dout=0x8000 and dout_ovr=1.
- Backpressure:
  - Hold dout_ready=0 for 5 cycles with din_valid=1.
  - Required: din_ready=0 after the first accept; dout is held stable; no sample is lost or duplicated after release.
- Commit boundary:
  - Pulse commit with ch_cnt=1.
  - Required: the swap happens only after the ch1 sample is accepted. din_ready is low for exactly one cycle, and coef_pending falls on the same edge.
  - A wr_en while pending does not change the shadow bank.
- Async reset mid-stream:
  - Assert rstn between samples.
  - Required: all outputs are 0 immediately.
  - After release, the first output is tagged ch0 and computed with zero history and zero coefficients, so dout=0.
